// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Mode constant sets and elaboration helpers for the VGA raster timing
// generator.
//   SXGA_* : 1280x1024@60, positive sync (default geometry of vga_timing_gen)
//   VGA_*  : 640x480@60, negative sync
//   calc_total : sum of the four sections of one axis
//   calc_clog2 : ceil(log2(v)), used to check a total fits the counter width
package vga_timing_pkg;

  localparam int SXGA_H_DISP  = 1280;
  localparam int SXGA_H_FRONT = 48;
  localparam int SXGA_H_SYNC  = 112;
  localparam int SXGA_H_BACK  = 248;
  localparam int SXGA_V_DISP  = 1024;
  localparam int SXGA_V_FRONT = 1;
  localparam int SXGA_V_SYNC  = 3;
  localparam int SXGA_V_BACK  = 38;
  localparam int SXGA_H_POL   = 1;
  localparam int SXGA_V_POL   = 1;

  localparam int VGA_H_DISP   = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_DISP   = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_H_POL    = 0;
  localparam int VGA_V_POL    = 0;

  function automatic int calc_total(input int disp, input int front,
                                    input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int calc_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter
// One raster axis: position counter plus combinational section decode.
// Sections in order: active, front porch, sync, back porch.
//   clk, rst : clock, synchronous active-high reset
//   en       : clock enable
//   last_in  : carry from the faster axis (tie high for the horizontal axis)
//   count    : current position, 0..TOTAL-1
//   wrap     : count is at TOTAL-1 and the carry is present
//   active   : count inside the active section
//   sync     : sync decode, already at the level selected by POL
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISP  = 1280,
  parameter int FRONT = 48,
  parameter int SYNC  = 112,
  parameter int BACK  = 248,
  parameter int POL   = 1,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          last_in,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int TOTAL = calc_total(DISP, FRONT, SYNC, BACK);

  if (DISP < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || calc_clog2(TOTAL) > CW) begin : g_param_err
    $error("vga_axis_counter: zero-length section or total exceeds 2**CW");
  end

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DISP_END   = CW'(DISP);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(DISP + FRONT);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(DISP + FRONT + SYNC - 1);
  localparam logic          POL_L      = (POL != 0);

  logic [CW-1:0] r_count;
  logic          w_in_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en && last_in) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

  assign wrap      = last_in && (r_count == LAST);
  assign active    = r_count < DISP_END;
  assign w_in_sync = (r_count >= SYNC_FIRST) && (r_count <= SYNC_LAST);
  assign sync      = w_in_sync ? POL_L : ~POL_L;
  assign count     = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator with pixel clock enable.
// Outputs are registered decodes of the (hc, vc) position, one enabled cycle
// behind the counters.
//   clk, rst          : clock, synchronous active-high reset (wins over pix_ce)
//   pix_ce            : raster advances / outputs load only when 1
//   hsync, vsync      : sync at the H_POL / V_POL active level
//   blank_n           : low outside active area (DAC)
//   sync_n            : DAC composite sync, tied low
//   disp_enable       : high inside active area
//   pix_x, pix_y      : current column / line
//   line_start        : one-clk strobe when column 0 is loaded
//   frame_start       : one-clk strobe when (0,0) is loaded
// Optional (macro VGA_TIMING_LOOKAHEAD_EN):
//   nxt_x, nxt_y, nxt_de : combinational position/enable that the main outputs
//                          will show after the next enabled cycle
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = SXGA_H_DISP,
  parameter int H_FRONT = SXGA_H_FRONT,
  parameter int H_SYNC  = SXGA_H_SYNC,
  parameter int H_BACK  = SXGA_H_BACK,
  parameter int V_DISP  = SXGA_V_DISP,
  parameter int V_FRONT = SXGA_V_FRONT,
  parameter int V_SYNC  = SXGA_V_SYNC,
  parameter int V_BACK  = SXGA_V_BACK,
  parameter int H_POL   = SXGA_H_POL,
  parameter int V_POL   = SXGA_V_POL,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          sync_n,
  output logic          disp_enable,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CW-1:0] nxt_x,
  output logic [CW-1:0] nxt_y,
  output logic          nxt_de
`endif
);

  localparam logic H_IDLE = (H_POL == 0);
  localparam logic V_IDLE = (V_POL == 0);

  logic [CW-1:0] w_hc, w_vc;
  logic          w_h_wrap, w_v_wrap;
  logic          w_h_act, w_v_act;
  logic          w_h_sync, w_v_sync;

  logic [CW-1:0] r_pix_x, r_pix_y;
  logic          r_hsync, r_vsync, r_de;
  logic          r_line_start, r_frame_start;
  // Track "counter sits at column 0 / at (0,0)" from the wrap carries instead
  // of comparing the counts against zero.
  logic          r_at_line0, r_at_origin;

  vga_axis_counter #(
    .DISP(H_DISP), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_POL), .CW(CW)
  ) u_h (
    .clk(clk), .rst(rst), .en(pix_ce), .last_in(1'b1),
    .count(w_hc), .wrap(w_h_wrap), .active(w_h_act), .sync(w_h_sync)
  );

  vga_axis_counter #(
    .DISP(V_DISP), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_POL), .CW(CW)
  ) u_v (
    .clk(clk), .rst(rst), .en(pix_ce), .last_in(w_h_wrap),
    .count(w_vc), .wrap(w_v_wrap), .active(w_v_act), .sync(w_v_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_hsync       <= H_IDLE;
      r_vsync       <= V_IDLE;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_at_line0    <= 1'b1;
      r_at_origin   <= 1'b1;
    end else if (pix_ce) begin
      r_pix_x       <= w_hc;
      r_pix_y       <= w_vc;
      r_hsync       <= w_h_sync;
      r_vsync       <= w_v_sync;
      r_de          <= w_h_act && w_v_act;
      r_line_start  <= r_at_line0;
      r_frame_start <= r_at_origin;
      r_at_line0    <= w_h_wrap;
      r_at_origin   <= w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign disp_enable = r_de;
  assign blank_n     = r_de;
  assign sync_n      = 1'b0;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  assign nxt_x  = w_hc;
  assign nxt_y  = w_vc;
  assign nxt_de = w_h_act && w_v_act;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HT = 16;
  localparam int VT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- small raster DUT ----------------
  logic       s_rst = 1'b1, s_ce = 1'b0;
  logic       s_hsync, s_vsync, s_blank_n, s_sync_n, s_de, s_ls, s_fs;
  logic [3:0] s_x, s_y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [3:0] s_nx, s_ny;
  logic       s_nde;
`endif

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1), .V_POL(1), .CW(4)
  ) u_small (
    .clk(clk), .rst(s_rst), .pix_ce(s_ce),
    .hsync(s_hsync), .vsync(s_vsync), .blank_n(s_blank_n), .sync_n(s_sync_n),
    .disp_enable(s_de), .pix_x(s_x), .pix_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .nxt_x(s_nx), .nxt_y(s_ny), .nxt_de(s_nde)
`endif
  );

  // ---------------- default SXGA DUT ----------------
  logic        x_rst = 1'b1, x_ce = 1'b0;
  logic        x_hsync, x_vsync, x_blank_n, x_sync_n, x_de, x_ls, x_fs;
  logic [11:0] x_x, x_y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [11:0] x_nx, x_ny;
  logic        x_nde;
`endif

  vga_timing_gen u_sxga (
    .clk(clk), .rst(x_rst), .pix_ce(x_ce),
    .hsync(x_hsync), .vsync(x_vsync), .blank_n(x_blank_n), .sync_n(x_sync_n),
    .disp_enable(x_de), .pix_x(x_x), .pix_y(x_y),
    .line_start(x_ls), .frame_start(x_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .nxt_x(x_nx), .nxt_y(x_ny), .nxt_de(x_nde)
`endif
  );

  // ---------------- VGA (negative polarity) DUT ----------------
  logic        v_rst = 1'b1, v_ce = 1'b0;
  logic        v_hsync, v_vsync, v_blank_n, v_sync_n, v_de, v_ls, v_fs;
  logic [9:0]  v_x, v_y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [9:0]  v_nx, v_ny;
  logic        v_nde;
`endif

  vga_timing_gen #(
    .H_DISP(VGA_H_DISP), .H_FRONT(VGA_H_FRONT), .H_SYNC(VGA_H_SYNC), .H_BACK(VGA_H_BACK),
    .V_DISP(VGA_V_DISP), .V_FRONT(VGA_V_FRONT), .V_SYNC(VGA_V_SYNC), .V_BACK(VGA_V_BACK),
    .H_POL(VGA_H_POL), .V_POL(VGA_V_POL), .CW(10)
  ) u_vga (
    .clk(clk), .rst(v_rst), .pix_ce(v_ce),
    .hsync(v_hsync), .vsync(v_vsync), .blank_n(v_blank_n), .sync_n(v_sync_n),
    .disp_enable(v_de), .pix_x(v_x), .pix_y(v_y),
    .line_start(v_ls), .frame_start(v_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .nxt_x(v_nx), .nxt_y(v_ny), .nxt_de(v_nde)
`endif
  );

  // ---------------- reference model for the small raster ----------------
  // Raster position kept as a linear pixel index within the frame.
  int m_pos = 0;
  int e_x = 0, e_y = 0, e_de = 0, e_hs = 0, e_vs = 0, e_ls = 0, e_fs = 0;

  task automatic model_step(input bit r, input bit ce);
    int x, y;
    if (r) begin
      m_pos = 0;
      e_x = 0; e_y = 0; e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0;
    end else if (ce) begin
      x = m_pos % HT;
      y = m_pos / HT;
      e_x  = x;
      e_y  = y;
      e_de = (x < 8 && y < 4) ? 1 : 0;
      e_hs = (x >= 10 && x <= 12) ? 1 : 0;
      e_vs = (y >= 5 && y <= 6) ? 1 : 0;
      e_ls = (x == 0) ? 1 : 0;
      e_fs = (m_pos == 0) ? 1 : 0;
      m_pos = (m_pos + 1) % (HT * VT);
    end else begin
      e_ls = 0;
      e_fs = 0;
    end
  endtask

  int cyc = 0;
  int last_fs = -1;
  int exp_period = 0;

  task automatic small_cycle(input bit r, input bit ce);
    s_rst = r;
    s_ce  = ce;
    @(posedge clk);
    model_step(r, ce);
    #1;
    cyc++;
    check_eq("pix_x", int'(s_x), e_x);
    check_eq("pix_y", int'(s_y), e_y);
    check_eq("disp_enable", int'(s_de), e_de);
    check_eq("blank_n", int'(s_blank_n), e_de);
    check_eq("hsync", int'(s_hsync), e_hs);
    check_eq("vsync", int'(s_vsync), e_vs);
    check_eq("line_start", int'(s_ls), e_ls);
    check_eq("frame_start", int'(s_fs), e_fs);
    check_eq("sync_n", int'(s_sync_n), 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    check_eq("nxt_x", int'(s_nx), m_pos % HT);
    check_eq("nxt_y", int'(s_ny), m_pos / HT);
    check_eq("nxt_de", int'(s_nde), ((m_pos % HT) < 8 && (m_pos / HT) < 4) ? 1 : 0);
`endif
    if (s_fs) begin
      if (last_fs >= 0 && exp_period != 0) check_eq("frame_period", cyc - last_fs, exp_period);
      last_fs = cyc;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int xp_rise, x_pulses, vp_fall, v_pulses, x_maxx, v_maxx, v_vs_ok;
    logic xp, vp;

    // reset state
    small_cycle(1'b1, 1'b0);
    small_cycle(1'b1, 1'b1);

    // continuous enable: two frames, period 128
    last_fs = -1; exp_period = 128;
    for (int i = 0; i < 2 * HT * VT + 4; i++) small_cycle(1'b0, 1'b1);

    // enable 1 of 3 cycles: period 384
    last_fs = -1; exp_period = 384;
    for (int i = 0; i < 3 * 2 * HT * VT + 6; i++) small_cycle(1'b0, (i % 3) == 0);

    // reset mid-frame at (5,2)
    exp_period = 0;
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      if (s_x == 4'd5 && s_y == 4'd2) found = 1'b1;
      else small_cycle(1'b0, 1'b1);
    end
    check_eq("reach_5_2", int'(found), 1);
    small_cycle(1'b1, 1'b1);
    check_eq("mid_rst_x", int'(s_x), 0);
    check_eq("mid_rst_hs", int'(s_hsync), 0);
    small_cycle(1'b0, 1'b1);
    check_eq("post_rst_fs", int'(s_fs), 1);
    check_eq("post_rst_de", int'(s_de), 1);

    // randomized enable and occasional reset
    for (int i = 0; i < 1500; i++)
      small_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

    // SXGA default and VGA negative-polarity geometry
    s_rst = 1'b1;
    x_ce = 1'b1; v_ce = 1'b1;
    @(posedge clk); #1;
    check_eq("sxga_rst_hs", int'(x_hsync), 0);
    check_eq("sxga_rst_vs", int'(x_vsync), 0);
    check_eq("vga_rst_hs", int'(v_hsync), 1);
    check_eq("vga_rst_vs", int'(v_vsync), 1);
    check_eq("vga_rst_blank", int'(v_blank_n), 0);
    x_rst = 1'b0; v_rst = 1'b0;
    xp = x_hsync; vp = v_hsync;
    xp_rise = -1; x_pulses = 0; vp_fall = -1; v_pulses = 0;
    x_maxx = 0; v_maxx = 0; v_vs_ok = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (x_hsync && !xp) begin
        if (xp_rise >= 0) check_eq("sxga_h_period", c - xp_rise, 1688);
        xp_rise = c;
      end
      if (!x_hsync && xp && xp_rise >= 0) begin
        check_eq("sxga_h_width", c - xp_rise, 112);
        x_pulses++;
      end
      if (!v_hsync && vp) begin
        if (vp_fall >= 0) check_eq("vga_h_period", c - vp_fall, 800);
        vp_fall = c;
      end
      if (v_hsync && !vp && vp_fall >= 0) begin
        check_eq("vga_h_width", c - vp_fall, 96);
        v_pulses++;
      end
      if (int'(x_x) > x_maxx) x_maxx = int'(x_x);
      if (int'(v_x) > v_maxx) v_maxx = int'(v_x);
      if (v_vsync !== 1'b1) v_vs_ok = 0;
      xp = x_hsync; vp = v_hsync;
    end
    check_eq("sxga_pulses_seen", int'(x_pulses >= 2), 1);
    check_eq("vga_pulses_seen", int'(v_pulses >= 4), 1);
    check_eq("sxga_max_x", x_maxx, 1687);
    check_eq("vga_max_x", v_maxx, 799);
    check_eq("vga_vsync_idle", v_vs_ok, 1);
    check_eq("vga_line", int'(v_y), 4000 / 800 - ((4000 % 800) == 0 ? 1 : 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
